im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot/load controller for the single-cycle RISC-V core's instruction memory (IM).
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into N-bit words. Writes the words sequentially into IM from address 0.
- Holds the CPU in reset while loading, then releases it.
- Owns the IM address port: muxes it between the loader (during load) and the CPU PC (during run).

Parameters:
N, 32, instruction word width (multiple of 8; 32 in this design)
DEPTH, 32, number of IM words
AW, 5, IM address width (log2 DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to (re)load IM; sampled in IDLE and RUN only
word_count  input  AW+1  number of words to load; latched on accepted start
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte, least-significant byte of each word first
byte_ready  output  1  loader accepts a byte this cycle
pc_addr  input  AW  CPU word-address for instruction fetch
addressIM  output  AW  address driven to IM
we_IM  output  1  IM write enable (IM write is synchronous on clk)
wdata_IM  output  N  IM write data
cpu_rst  output  1  holds the CPU in reset while high
busy  output  1  load in progress (LOAD or WRITE)
done  output  1  IM loaded, CPU running

Behaviour:
- Reset values: state=IDLE, cpu_rst=1, byte_ready=0, we_IM=0, wdata_IM=0, busy=0, done=0, byte index=0, word index=0, addressIM=0.
- Reset does not clear IM contents. A reset mid-load leaves already-written words intact and returns to IDLE.
- States: IDLE, LOAD, WRITE, RUN. Registered outputs are decoded from state.
- IDLE: cpu_rst=1.
  - On start: latch cnt = min(word_count, DEPTH), clear indices.
  - cnt==0 -> RUN; else -> LOAD.
- LOAD: byte_ready=1, busy=1.
  - Byte accepted iff byte_valid&&byte_ready.
  - Accepted byte goes to buffer bits [8*bidx+7 : 8*bidx]; bidx increments.
  - Accepting byte with bidx==N/8-1 -> WRITE, bidx wraps to 0.
  - byte_valid low stalls indefinitely, with no timeout.
- WRITE: exactly one cycle; byte_ready=0, we_IM=1, addressIM=widx, wdata_IM=buffer.
  - widx increments.
  - If widx+1==cnt -> RUN, else -> LOAD.
- RUN: cpu_rst=0, done=1, busy=0, addressIM=pc_addr (combinational pass-through, zero latency).
  - In all other states addressIM=widx.
  - start in RUN -> same transition as in IDLE; cpu_rst returns to 1 on that edge and done drops.
- start in LOAD/WRITE is ignored. word_count is sampled only with an accepted start.
- Timing with byte_valid held high, start accepted at edge 0:
  - Bytes accepted at edges 1..4 (N=32), write cycle follows.
  - Each word costs 5 cycles.
  - RUN is entered at edge 5*cnt; cpu_rst is low in the cycle after that edge.
- Width rules:
  - widx is AW+1 bits internally, compared against cnt; only the low AW bits drive addressIM.
  - word_count > DEPTH saturates to DEPTH, so the address never wraps.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package im_pkg:
  - state enum {IDLE, LOAD, WRITE, RUN}
  - BYTES_PER_WORD = N/8
  - default N/DEPTH/AW constants shared with the IM and core top
- One natural sub-module: im_word_packer. Holds the byte index and shift/insert of accepted bytes into an N-bit buffer; outputs word_full on the last byte.
- The FSM, counters and address mux stay in im_loader.

Test Plan:
1. reset high 2 cycles -> cpu_rst=1, done=0, busy=0, byte_ready=0, we_IM=0. Then start with word_count=2 and bytes 13 00 00 00 93 00 10 00 streamed continuously -> we_IM pulses at edges 5 and 10; IM[0]=0x00000013, IM[1]=0x00100093; done=1, cpu_rst=0 from edge 10.
2. Same load with byte_valid low for 3 cycles between bytes 2 and 3 -> byte_ready stays high and no byte is lost; IM[0]=0x00000013; RUN is reached 3 cycles later than in scenario 1.
3. In RUN, drive pc_addr=0,1 -> addressIM follows in the same cycle; the IM data output returns the loaded words. word_count=40 -> exactly 32 writes, addresses 0..31, then RUN.
4. start with word_count=0 -> RUN at the next edge with no we_IM pulse. start pulsed during LOAD -> ignored; the load completes with the original count.
5. reset asserted after 1 of 3 words is written -> IDLE, cpu_rst=1, IM[0] retained. A subsequent start in RUN reloads: cpu_rst=1 and done=0 on the start edge, and words are rewritten from address 0.

Source files
------------

// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared IM geometry, loader state codes and count saturation helper
package im_pkg;

    localparam int N              = 32;
    localparam int DEPTH          = 32;
    localparam int AW             = 5;
    localparam int BYTES_PER_WORD = N / 8;
    localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_RUN   = 2'd3;

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    // Clamp the requested word count so the write address can never wrap.
    function automatic logic [AW:0] sat_count(input logic [AW:0] wc);
        return (wc > DEPTH_CNT) ? DEPTH_CNT : wc;
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream handshake and IM write/address port bundle
interface im_loader_if;
    import im_pkg::*;

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] addressIM;
    logic          we_IM;
    logic [N-1:0]  wdata_IM;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, addressIM, we_IM, wdata_IM
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, addressIM, we_IM, wdata_IM
    );
endinterface

// File: rtl/im_word_packer.sv
// rtl/im_word_packer.sv - little-endian byte-to-word packer with last-byte flag
module im_word_packer
    import im_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         accept,
    input  logic [7:0]   byte_in,
    output logic [N-1:0] word,
    output logic         word_full
);

    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_WORD - 1);

    logic [BIDX_W-1:0] r_bidx;
    logic [N-1:0]      r_buf;

    assign word      = r_buf;
    assign word_full = accept && (r_bidx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bidx <= '0;
            r_buf  <= '0;
        end else if (clear) begin
            r_bidx <= '0;
        end else if (accept) begin
            r_buf[8*r_bidx +: 8] <= byte_in;
            r_bidx               <= word_full ? '0 : r_bidx + BIDX_W'(1);
        end
    end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - IM boot loader: streams bytes into IM, holds the CPU in reset until done
module im_loader
    import im_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   word_count,
    input  logic [AW-1:0] pc_addr,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    im_loader_if.slave    bus
);

    state_t      r_state;
    logic [AW:0] r_cnt;
    logic [AW:0] r_widx;

    logic          w_start_ok;
    logic          w_accept;
    logic          w_word_full;
    logic [N-1:0]  w_word;
    logic [AW:0]   w_cnt_in;
    logic [AW:0]   w_widx_nxt;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_accept   = bus.byte_valid && bus.byte_ready;
    assign w_cnt_in   = sat_count(word_count);
    assign w_widx_nxt = r_widx + (AW + 1)'(1);

    im_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_start_ok),
        .accept    (w_accept),
        .byte_in   (bus.byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_widx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_start_ok) begin
                        r_cnt   <= w_cnt_in;
                        r_widx  <= '0;
                        r_state <= (w_cnt_in == '0) ? ST_RUN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_word_full) r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_widx  <= w_widx_nxt;
                    r_state <= (w_widx_nxt == r_cnt) ? ST_RUN : ST_LOAD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The CPU owns the IM address only while running; otherwise the loader's word index does.
    assign bus.addressIM  = (r_state == ST_RUN) ? pc_addr : r_widx[AW-1:0];
    assign bus.byte_ready = (r_state == ST_LOAD);
    assign bus.we_IM      = (r_state == ST_WRITE);
    assign bus.wdata_IM   = w_word;
    assign cpu_rst        = (r_state != ST_RUN);
    assign done           = (r_state == ST_RUN);
    assign busy           = (r_state == ST_LOAD) || (r_state == ST_WRITE);

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized and directed self-checking bench for im_loader
module tb_im_loader;
    import im_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic [AW-1:0] pc_addr;
    logic          cpu_rst, busy, done;

    im_loader_if bus();

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .pc_addr    (pc_addr),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous write, asynchronous read
    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] im_rdata;
    assign im_rdata = mem[bus.addressIM];

    int           edge_num = 0;
    int           wr_addr[$];
    logic [N-1:0] wr_data[$];
    int           wr_edge[$];
    int           run_edge = -1;
    logic         prev_done = 1'b0;

    always @(posedge clk) begin
        edge_num = edge_num + 1;
        if (bus.we_IM) begin
            mem[bus.addressIM] <= bus.wdata_IM;
            wr_addr.push_back(int'(bus.addressIM));
            wr_data.push_back(bus.wdata_IM);
            wr_edge.push_back(edge_num);
        end
    end

    always @(negedge clk) begin
        if (done && !prev_done) run_edge = edge_num;
        prev_done = done;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] word_of(input logic [7:0] q[$], input int k);
        logic [N-1:0] w;
        for (int j = 0; j < BYTES_PER_WORD; j++) w[8*j +: 8] = q[BYTES_PER_WORD*k + j];
        return w;
    endfunction

    function automatic int sat(input int wc);
        return (wc > DEPTH) ? DEPTH : wc;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_edge.delete();
        run_edge = -1;
    endtask

    task automatic pulse_start(input int wc, output int sedge);
        word_count = (AW + 1)'(wc);
        start      = 1'b1;
        sedge      = edge_num + 1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int guard;
        bus.byte_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("ready_in_stall", bus.byte_ready, 1'b1);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        guard = 0;
        while (!bus.byte_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("ready_timeout", bus.byte_ready, 1'b1);
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic stream(input logic [7:0] b[$], input int st[$]);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], st[i]);
        tick();
        tick();
    endtask

    // Reference: words packed LSB-first, written to 0..cnt-1, 5 cycles per word plus stalls
    task automatic expect_load(input string tag, input int wc, input logic [7:0] b[$],
                               input int st[$], input int sedge);
        int cnt, acc, stall_sum, n;
        cnt = sat(wc);
        check({tag, "_nwrites"}, wr_addr.size(), cnt);
        n = (wr_addr.size() < cnt) ? wr_addr.size() : cnt;
        stall_sum = 0;
        for (int i = 0; i < BYTES_PER_WORD * cnt; i++) stall_sum += st[i];
        acc = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < BYTES_PER_WORD; j++) acc += st[BYTES_PER_WORD*k + j];
            check({tag, "_waddr"}, wr_addr[k], k);
            check({tag, "_wdata"}, wr_data[k], word_of(b, k));
            check({tag, "_wedge"}, wr_edge[k], sedge + 5*(k + 1) + acc);
            check({tag, "_mem"}, mem[k], word_of(b, k));
        end
        check({tag, "_run_edge"}, run_edge, sedge + 5*cnt + stall_sum);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic make_random(input int nbytes, output logic [7:0] b[$], output int st[$]);
        b.delete();
        st.delete();
        for (int i = 0; i < nbytes; i++) begin
            b.push_back(8'($urandom));
            st.push_back((i % BYTES_PER_WORD == 0) ? 0 : int'($urandom_range(0, 2)));
        end
    endtask

    task automatic do_load(input string tag, input int wc, input logic [7:0] b[$], input int st[$]);
        int sedge;
        clear_log();
        pulse_start(wc, sedge);
        stream(b, st);
        expect_load(tag, wc, b, st, sedge);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        int         st[$];
        int         sedge, wc, a;

        reset = 1'b1; start = 1'b0; word_count = '0; pc_addr = '0;
        bus.byte_valid = 1'b0; bus.byte_data = 8'h00;

        // 1: reset state, then two words streamed back to back
        tick(); tick();
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", bus.byte_ready, 1'b0);
        check("rst_we", bus.we_IM, 1'b0);
        check("rst_wdata", bus.wdata_IM, '0);
        check("rst_addr", bus.addressIM, '0);
        reset = 1'b0;
        tick();
        b  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        st = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_load("s1", 2, b, st);
        check("s1_word0", mem[0], 32'h0000_0013);
        check("s1_word1", mem[1], 32'h0010_0093);

        // 2: three-cycle stall mid-word, restarted from RUN
        st = '{0, 0, 0, 3, 0, 0, 0, 0};
        do_load("s2", 2, b, st);

        // 3: PC pass-through, then oversize count saturates at DEPTH
        pc_addr = 5'd0; #1;
        check("s3_addr0", bus.addressIM, 5'd0);
        check("s3_rdata0", im_rdata, 32'h0000_0013);
        pc_addr = 5'd1; #1;
        check("s3_addr1", bus.addressIM, 5'd1);
        check("s3_rdata1", im_rdata, 32'h0010_0093);
        make_random(BYTES_PER_WORD * DEPTH, b, st);
        do_load("s3_sat", 40, b, st);
        for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(0, DEPTH - 1));
            pc_addr = AW'(a); #1;
            check("s3_fetch", im_rdata, word_of(b, a));
        end

        // randomized loads
        for (int r = 0; r < 4; r++) begin
            wc = int'($urandom_range(1, 8));
            make_random(BYTES_PER_WORD * wc, b, st);
            do_load("rnd", wc, b, st);
        end

        // 4: zero-count start, then start ignored during LOAD
        reset = 1'b1; tick(); reset = 1'b0; tick();
        clear_log();
        pulse_start(0, sedge);
        tick();
        check("s4_zero_nwrites", wr_addr.size(), 0);
        check("s4_zero_run_edge", run_edge, sedge);
        check("s4_zero_done", done, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        clear_log();
        make_random(2 * BYTES_PER_WORD, b, st);
        for (int i = 0; i < b.size(); i++) st[i] = 0;
        st[2] = 1;
        pulse_start(2, sedge);
        send_byte(b[0], 0);
        send_byte(b[1], 0);
        word_count = 6'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i < b.size(); i++) send_byte(b[i], 0);
        tick(); tick();
        expect_load("s4_ign", 2, b, st, sedge);

        // 5: reset mid-load keeps written words; restart from RUN rewrites from 0
        clear_log();
        make_random(3 * BYTES_PER_WORD, b, st);
        pulse_start(3, sedge);
        for (int i = 0; i < BYTES_PER_WORD + 2; i++) send_byte(b[i], 0);
        reset = 1'b1;
        tick();
        check("s5_rst_cpu_rst", cpu_rst, 1'b1);
        check("s5_rst_done", done, 1'b0);
        check("s5_rst_busy", busy, 1'b0);
        check("s5_rst_ready", bus.byte_ready, 1'b0);
        reset = 1'b0;
        tick();
        check("s5_nwrites", wr_addr.size(), 1);
        check("s5_mem0_kept", mem[0], word_of(b, 0));
        make_random(BYTES_PER_WORD, b, st);
        do_load("s5_one", 1, b, st);
        clear_log();
        make_random(2 * BYTES_PER_WORD, b, st);
        pulse_start(2, sedge);
        check("s5_restart_cpu_rst", cpu_rst, 1'b1);
        check("s5_restart_done", done, 1'b0);
        check("s5_restart_busy", busy, 1'b1);
        stream(b, st);
        expect_load("s5_reload", 2, b, st, sedge);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
